// File: rtl/random_stimulus_bank.sv
// Bank of independent 32-bit Galois LFSR channels with selectable advance modes
// (freeze, free-run, fixed interval, on-demand handshake) and seed reload.
module random_stimulus_bank #(
   parameter int          WIDTH    = 32,
   parameter int          CHANNELS = 4,
   parameter logic [31:0] SEED     = 32'h0000_0001,
   parameter int          PERIOD   = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                mode,
   input  logic                      step_req,
   output logic                      step_ack,
   input  logic                      seed_load,
   input  logic [31:0]               seed_in,
   output logic [CHANNELS*WIDTH-1:0] rand_out,
   output logic                      rand_valid,
   output logic [15:0]               advance_count
);

   typedef enum logic [1:0] {
      MODE_FREEZE   = 2'b00,
      MODE_FREE     = 2'b01,
      MODE_INTERVAL = 2'b10,
      MODE_DEMAND   = 2'b11
   } mode_t;

   localparam logic [31:0] TAPS   = 32'h8020_0003;
   localparam logic [31:0] GOLDEN = 32'h9E37_79B9;
   localparam logic [15:0] LAST   = 16'(PERIOD - 1);

   // An all-zero Galois state would lock up, so a zero derived seed becomes 1.
   function automatic logic [31:0] derive_seed(input logic [31:0] base, input int unsigned k);
      logic [31:0] d;
      d = base ^ (k[31:0] * GOLDEN);
      if (d == 32'h0) d = 32'h0000_0001;
      return d;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
   endfunction

   mode_t       cur_mode;
   logic [31:0] state [CHANNELS];
   logic [15:0] icnt;
   logic        interval_hit;
   logic        advance;
   logic        ack_next;

   assign cur_mode     = mode_t'(mode);
   assign interval_hit = (icnt == LAST);

   // Decide whether this cycle advances; a seed load always wins over an advance.
   always_comb begin
      advance  = 1'b0;
      ack_next = 1'b0;
      case (cur_mode)
         MODE_FREE:     advance = 1'b1;
         MODE_INTERVAL: advance = interval_hit;
         MODE_DEMAND: begin
            ack_next = step_req && !step_ack && !seed_load;
            advance  = ack_next;
         end
         default: ;
      endcase
      if (seed_load) advance = 1'b0;
   end

   // Interval counter idles at zero outside interval mode so entry always waits a full period.
   always_ff @(posedge clk) begin
      if (reset) begin
         icnt <= 16'h0;
      end else if (seed_load || cur_mode != MODE_INTERVAL || interval_hit) begin
         icnt <= 16'h0;
      end else begin
         icnt <= icnt + 16'h1;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (reset) begin
            state[k] <= derive_seed(SEED, k);
         end else if (seed_load) begin
            state[k] <= derive_seed(seed_in, k);
         end else if (advance) begin
            state[k] <= lfsr_step(state[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_ack      <= 1'b0;
         rand_valid    <= 1'b0;
         advance_count <= 16'h0;
      end else begin
         step_ack   <= ack_next;
         rand_valid <= advance || seed_load;
         if (seed_load) begin
            advance_count <= 16'h0;
         end else if (advance) begin
            advance_count <= advance_count + 16'h1;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign rand_out[g*WIDTH +: WIDTH] = state[g][WIDTH-1:0];
   end

endmodule

// File: tb/tb_random_stimulus_bank.sv
// Scoreboard bench for random_stimulus_bank: stimulus pushes expected values on
// every predicted rand_valid pulse, an independent monitor pops and compares them.
module tb_random_stimulus_bank;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   mode;
   logic         step_req;
   logic         seed_load;
   logic [31:0]  seed_in;
   logic         step_ack;
   logic [127:0] rand_out;
   logic         rand_valid;
   logic [15:0]  advance_count;
   logic         step_ack8;
   logic [15:0]  rand_out8;
   logic         rand_valid8;
   logic [15:0]  advance_count8;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] c0;
      logic [31:0] c1;
      logic [15:0] cnt;
   } exp_t;
   exp_t sbq[$];

   logic [31:0] m_s [4];
   logic [15:0] m_cnt;
   logic [15:0] m_icnt;
   logic        m_ack;

   random_stimulus_bank dut (
      .clk(clk), .reset(reset), .mode(mode), .step_req(step_req), .step_ack(step_ack),
      .seed_load(seed_load), .seed_in(seed_in), .rand_out(rand_out),
      .rand_valid(rand_valid), .advance_count(advance_count)
   );

   random_stimulus_bank #(.WIDTH(8), .CHANNELS(2)) dut8 (
      .clk(clk), .reset(reset), .mode(mode), .step_req(step_req), .step_ack(step_ack8),
      .seed_load(seed_load), .seed_in(seed_in), .rand_out(rand_out8),
      .rand_valid(rand_valid8), .advance_count(advance_count8)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] derive(input logic [31:0] base, input int k);
      logic [31:0] d;
      d = base ^ (32'(k) * 32'h9E37_79B9);
      return (d == 32'h0) ? 32'h1 : d;
   endfunction

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model, then clock it in.
   task automatic applyStimulus(input logic r, input logic [1:0] md, input logic req,
                                input logic sl, input logic [31:0] si);
      logic adv, ackn, hit;
      reset = r; mode = md; step_req = req; seed_load = sl; seed_in = si;
      if (r) begin
         for (int k = 0; k < 4; k++) m_s[k] = derive(32'h1, k);
         m_cnt = 16'h0; m_icnt = 16'h0; m_ack = 1'b0;
      end else begin
         hit  = (m_icnt == 16'd2);
         adv  = 1'b0;
         ackn = 1'b0;
         case (md)
            2'b01: adv = 1'b1;
            2'b10: adv = hit;
            2'b11: begin ackn = req && !m_ack && !sl; adv = ackn; end
            default: ;
         endcase
         if (sl) adv = 1'b0;
         m_icnt = (sl || md != 2'b10 || hit) ? 16'h0 : m_icnt + 16'h1;
         if (sl) begin
            for (int k = 0; k < 4; k++) m_s[k] = derive(si, k);
            m_cnt = 16'h0;
         end else if (adv) begin
            for (int k = 0; k < 4; k++) m_s[k] = lstep(m_s[k]);
            m_cnt = m_cnt + 16'h1;
         end
         m_ack = ackn;
         if (sl || adv) sbq.push_back('{m_s[0], m_s[1], m_cnt});
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rand_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rand_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_valid actual=1 required=0 at %0t", $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("sb_ch0", {32'h0, rand_out[31:0]}, {32'h0, e.c0});
            checkOutput("sb_ch1", {32'h0, rand_out[63:32]}, {32'h0, e.c1});
            checkOutput("sb_count", {48'h0, advance_count}, {48'h0, e.cnt});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] interval_cnt [9];
      logic        ack_pattern [6];
      interval_cnt = '{16'd2, 16'd2, 16'd3, 16'd3, 16'd3, 16'd4, 16'd4, 16'd4, 16'd5};
      ack_pattern  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_ch0", {32'h0, rand_out[31:0]}, 64'h0000_0001);
      checkOutput("rst_ch1", {32'h0, rand_out[63:32]}, 64'h9E37_79B8);
      checkOutput("rst_ch2", {32'h0, rand_out[95:64]}, 64'h3C6E_F373);
      checkOutput("rst_valid", {63'h0, rand_valid}, 64'h0);
      checkOutput("rst_ack", {63'h0, step_ack}, 64'h0);
      checkOutput("rst_count", {48'h0, advance_count}, 64'h0);
      checkOutput("rst_narrow", {48'h0, rand_out8}, 64'hB801);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
         checkOutput("freeze_narrow", {48'h0, rand_out8}, 64'hB801);
         checkOutput("freeze_valid", {63'h0, rand_valid8}, 64'h0);
      end

      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
      checkOutput("free1_ch0", {32'h0, rand_out[31:0]}, 64'h8020_0003);
      checkOutput("free1_ch1", {32'h0, rand_out[63:32]}, 64'h4F1B_BCDC);
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
      checkOutput("free2_ch0", {32'h0, rand_out[31:0]}, 64'hC030_0002);
      checkOutput("free2_count", {48'h0, advance_count}, 64'd2);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
         checkOutput("interval_count", {48'h0, advance_count}, {48'h0, interval_cnt[i]});
      end

      for (int i = 0; i < 6; i++) begin
         checkOutput("demand_ack", {63'h0, step_ack}, {63'h0, ack_pattern[i]});
         applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      end
      checkOutput("demand_count", {48'h0, advance_count}, 64'd8);

      applyStimulus(1'b0, 2'b01, 1'b0, 1'b1, 32'h0);
      checkOutput("seed0_ch0", {32'h0, rand_out[31:0]}, 64'h0000_0001);
      checkOutput("seed0_ch1", {32'h0, rand_out[63:32]}, 64'h9E37_79B9);
      checkOutput("seed0_count", {48'h0, advance_count}, 64'h0);
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
      checkOutput("seed0_next", {32'h0, rand_out[31:0]}, 64'h8020_0003);

      applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 32'h1234_5678);
      checkOutput("seedreq_ack", {63'h0, step_ack}, 64'h0);
      checkOutput("seedreq_ch0", {32'h0, rand_out[31:0]}, 64'h1234_5678);
      checkOutput("seedreq_count", {48'h0, advance_count}, 64'h0);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      checkOutput("seedreq_late_ack", {63'h0, step_ack}, 64'h1);
      checkOutput("seedreq_late_count", {48'h0, advance_count}, 64'd1);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      checkOutput("ack_holdoff", {63'h0, step_ack}, 64'h0);

      applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 32'h0000_FFFF);
      checkOutput("midrst_ack", {63'h0, step_ack}, 64'h0);
      checkOutput("midrst_valid", {63'h0, rand_valid}, 64'h0);
      checkOutput("midrst_ch0", {32'h0, rand_out[31:0]}, 64'h0000_0001);
      checkOutput("midrst_ch1", {32'h0, rand_out[63:32]}, 64'h9E37_79B8);
      checkOutput("midrst_count", {48'h0, advance_count}, 64'h0);

      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("modechg_count", {48'h0, advance_count}, 64'd1);

      @(negedge clk);
      #1;
      checkOutput("sb_drain", 64'(sbq.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
